// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: N valid/ready request channels in, one registered stream out.
interface rr_arb_mux_if #(
  parameter int DW = 32,
  parameter int NI = 4
);
  localparam int SW = $clog2(NI);

  logic [NI-1:0]    in_valid;
  logic [NI-1:0]    in_ready;
  logic [NI*DW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [SW-1:0]    out_src;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_arb_mux.sv
// N-input arbitrated mux with one output register stage; round-robin or fixed-priority grant.
module rr_arb_mux #(
  parameter int data_width = 32,
  parameter int num_inputs = 4,
  parameter bit rr_mode    = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  rr_arb_mux_if.slave bus
);
  localparam int sel_width = $clog2(num_inputs);

  logic [sel_width-1:0]  ptr_q, ptr_d;
  logic                  out_valid_q;
  logic [data_width-1:0] out_data_q;
  logic [sel_width-1:0]  out_src_q;

  logic                  load_en;
  logic                  gnt_found;
  logic [sel_width-1:0]  gnt_idx;
  logic [num_inputs-1:0] in_ready_c;
  int                    idx;
  int                    nxt;

  assign load_en = !out_valid_q || bus.out_ready;

  // Search starts at the pointer; fixed-priority mode keeps the pointer at 0 so the same loop applies.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < num_inputs; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= num_inputs) idx = idx - num_inputs;
      if (!gnt_found && bus.in_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[sel_width-1:0];
      end
    end
  end

  always_comb begin
    in_ready_c = '0;
    if (load_en && gnt_found) in_ready_c[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    nxt   = int'(gnt_idx) + 1;
    if (nxt >= num_inputs) nxt = 0;
    if (rr_mode && load_en && gnt_found) ptr_d = nxt[sel_width-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (load_en) begin
        out_valid_q <= gnt_found;
        if (gnt_found) begin
          out_data_q <= bus.in_data[int'(gnt_idx)*data_width +: data_width];
          out_src_q  <= gnt_idx;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed and scoreboarded random checks of rr_arb_mux in RR (N=4, N=5) and fixed-priority (N=4) builds.
module tb_rr_arb_mux;
  logic clk;
  logic reset_n;
  int   nvec = 0;
  int   nerr = 0;

  rr_arb_mux_if #(.DW(32), .NI(4)) b4 ();
  rr_arb_mux_if #(.DW(32), .NI(4)) bf ();
  rr_arb_mux_if #(.DW(32), .NI(5)) b5 ();

  rr_arb_mux #(.data_width(32), .num_inputs(4), .rr_mode(1'b1)) u4 (.clk(clk), .reset_n(reset_n), .bus(b4));
  rr_arb_mux #(.data_width(32), .num_inputs(4), .rr_mode(1'b0)) uf (.clk(clk), .reset_n(reset_n), .bus(bf));
  rr_arb_mux #(.data_width(32), .num_inputs(5), .rr_mode(1'b1)) u5 (.clk(clk), .reset_n(reset_n), .bus(b5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic set4(input logic [31:0] base);
    for (int i = 0; i < 4; i++) b4.in_data[i*32 +: 32] = base + i;
  endtask

  typedef struct packed { logic [1:0] src; logic [31:0] data; } beat_t;
  beat_t sb[$];
  beat_t bt;
  int    wait_cnt [4];
  int    max_wait;
  int    mptr;
  int    g;
  logic [3:0] exp_rdy;
  logic [3:0] v;

  initial begin
    reset_n = 1'b0;
    b4.in_valid = '0; b4.in_data = '0; b4.out_ready = 1'b0;
    bf.in_valid = '0; bf.in_data = '0; bf.out_ready = 1'b0;
    b5.in_valid = '0; b5.in_data = '0; b5.out_ready = 1'b0;
    edge1(); edge1();
    chk("rst_v4", 64'(b4.out_valid), 64'd0);
    chk("rst_d4", 64'(b4.out_data), 64'd0);
    chk("rst_s4", 64'(b4.out_src), 64'd0);
    chk("rst_vf", 64'(bf.out_valid), 64'd0);
    chk("rst_v5", 64'(b5.out_valid), 64'd0);
    reset_n = 1'b1;

    // Reset while a beat is held under backpressure
    b4.in_valid = 4'b0100; b4.in_data[2*32 +: 32] = 32'hA5A5_0002;
    edge1();
    chk("t1_v", 64'(b4.out_valid), 64'd1);
    chk("t1_s", 64'(b4.out_src), 64'd2);
    reset_n = 1'b0;
    #1;
    chk("t1_rv", 64'(b4.out_valid), 64'd0);
    chk("t1_rd", 64'(b4.out_data), 64'd0);
    chk("t1_rs", 64'(b4.out_src), 64'd0);
    b4.in_valid = '0;
    edge1();
    reset_n = 1'b1;

    // RR fairness: first grant after reset goes to ch0
    set4(32'h100);
    b4.in_valid = 4'hF; b4.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_rdy = 4'b0001 << (k % 4);
      chk("t2_rdy", 64'(b4.in_ready), 64'(exp_rdy));
      edge1();
      chk("t2_src", 64'(b4.out_src), 64'(k % 4));
      chk("t2_dat", 64'(b4.out_data), 64'(32'h100 + k % 4));
    end

    // Backpressure: pointer ends at 3 after ch2 accepted
    b4.in_valid = 4'b0100; b4.in_data[2*32 +: 32] = 32'hDEADBEEF;
    edge1();
    chk("t4_dat", 64'(b4.out_data), 64'hDEADBEEF);
    chk("t4_src", 64'(b4.out_src), 64'd2);
    set4(32'h200);
    b4.in_valid = 4'hF; b4.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_rdy0", 64'(b4.in_ready), 64'd0);
      edge1();
      chk("t4_hold", 64'(b4.out_data), 64'hDEADBEEF);
      chk("t4_vld", 64'(b4.out_valid), 64'd1);
    end
    b4.out_ready = 1'b1;
    #1;
    chk("t4_rdy3", 64'(b4.in_ready), 64'b1000);
    edge1();
    chk("t4_src3", 64'(b4.out_src), 64'd3);
    chk("t4_dat3", 64'(b4.out_data), 64'h203);
    b4.in_valid = '0;
    edge1();
    chk("t4_drain", 64'(b4.out_valid), 64'd0);
    chk("t4_keep", 64'(b4.out_src), 64'd3);

    // Fixed priority
    for (int i = 0; i < 4; i++) bf.in_data[i*32 +: 32] = 32'hF00 + i;
    bf.in_valid = 4'b1010; bf.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_rdy", 64'(bf.in_ready), 64'b0010);
      edge1();
      chk("t3_src1", 64'(bf.out_src), 64'd1);
    end
    bf.in_valid = 4'b1000;
    edge1();
    chk("t3_src3", 64'(bf.out_src), 64'd3);
    chk("t3_dat3", 64'(bf.out_data), 64'hF03);

    // N=5 wrap
    for (int i = 0; i < 5; i++) b5.in_data[i*32 +: 32] = 32'h500 + i;
    b5.out_ready = 1'b1;
    b5.in_valid = 5'b10000;
    #1;
    chk("t5_rdy4", 64'(b5.in_ready), 64'b10000);
    edge1();
    chk("t5_src4", 64'(b5.out_src), 64'd4);
    b5.in_valid = 5'b00001;
    edge1();
    chk("t5_src0", 64'(b5.out_src), 64'd0);
    chk("t5_dat0", 64'(b5.out_data), 64'h500);
    b5.in_valid = '0;
    edge1();
    chk("t5_idle", 64'(b5.out_valid), 64'd0);
    b5.in_valid = 5'b11111;
    #1;
    chk("t5_ptr1", 64'(b5.in_ready), 64'b00010);
    edge1();
    b5.in_valid = '0;

    // Random traffic on the N=4 RR build against a scoreboard and pointer model
    reset_n = 1'b0; b4.in_valid = '0; b4.out_ready = 1'b0;
    edge1();
    reset_n = 1'b1;
    mptr = 0; max_wait = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      v = 4'($urandom_range(0, 15));
      b4.in_valid = v;
      b4.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) b4.in_data[i*32 +: 32] = $urandom;
      #1;
      exp_rdy = '0; g = -1;
      if (!b4.out_valid || b4.out_ready)
        for (int k = 0; k < 4; k++)
          if (g < 0 && v[(mptr + k) % 4]) g = (mptr + k) % 4;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("rnd_rdy", 64'(b4.in_ready), 64'(exp_rdy));
      if (b4.out_valid && b4.out_ready) begin
        if (sb.size() == 0) chk("rnd_extra", 64'd1, 64'd0);
        else begin
          bt = sb.pop_front();
          chk("rnd_src", 64'(b4.out_src), 64'(bt.src));
          chk("rnd_dat", 64'(b4.out_data), 64'(bt.data));
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (!v[i]) wait_cnt[i] = 0;
        else if (b4.in_ready[i]) wait_cnt[i] = 0;
        else if (b4.in_ready != 0) wait_cnt[i]++;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      for (int i = 0; i < 4; i++)
        if (v[i] && b4.in_ready[i]) begin
          bt.src = 2'(i);
          bt.data = b4.in_data[i*32 +: 32];
          sb.push_back(bt);
          mptr = (i + 1) % 4;
        end
      edge1();
    end
    b4.in_valid = '0; b4.out_ready = 1'b1;
    #1;
    if (b4.out_valid) begin
      if (sb.size() == 0) chk("rnd_extra", 64'd1, 64'd0);
      else begin
        bt = sb.pop_front();
        chk("rnd_lsrc", 64'(b4.out_src), 64'(bt.src));
        chk("rnd_ldat", 64'(b4.out_data), 64'(bt.data));
      end
    end
    edge1();
    chk("rnd_empty", 64'(sb.size()), 64'd0);
    chk("rnd_fair", 64'(max_wait <= 4), 64'd1);
    chk("rnd_drain", 64'(b4.out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
